// File: rtl/pregfile_wb_arbiter_pkg.sv
// Shared constants for the physical register file writeback arbiter.
// Holds the default widths, source indices and a round-robin wrap helper.
package pregfile_wb_arbiter_pkg;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_PREG_W  = 6;
    localparam int DEF_DATA_W  = 64;

    typedef enum logic [1:0] {
        SRC_ALU0 = 2'd0,
        SRC_ALU1 = 2'd1,
        SRC_MDU  = 2'd2,
        SRC_LSU  = 2'd3
    } src_id_e;

    function automatic int rr_wrap_inc(input int idx, input int num);
        return (idx + 1) % num;
    endfunction

endpackage

// File: rtl/pregfile_wb_arbiter_slot.sv
// One-entry holding buffer for a single result source.
// It can take a new result in the same cycle its current entry retires.
module wb_result_slot
    import pregfile_wb_arbiter_pkg::*;
#(
    parameter int PREG_W = DEF_PREG_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [PREG_W-1:0] load_prd,
    input  logic [DATA_W-1:0] load_data,
    input  logic              retire,
    output logic              ready,
    output logic              occupied,
    output logic [PREG_W-1:0] prd,
    output logic [DATA_W-1:0] data
);

    logic              occ_q, occ_d;
    logic [PREG_W-1:0] prd_q, prd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load;

    always_comb begin
        ready  = !reset && (!occ_q || retire);
        load   = load_valid && ready;
        occ_d  = occ_q;
        prd_d  = prd_q;
        data_d = data_q;
        if (load) begin
            occ_d  = 1'b1;
            prd_d  = load_prd;
            data_d = load_data;
        end else if (retire) begin
            occ_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q  <= 1'b0;
            prd_q  <= '0;
            data_q <= '0;
        end else begin
            occ_q  <= occ_d;
            prd_q  <= prd_d;
            data_q <= data_d;
        end
    end

    assign occupied = occ_q;
    assign prd      = prd_q;
    assign data     = data_q;

endmodule

// File: rtl/pregfile_wb_arbiter.sv
// Writeback arbiter: buffers per-source results and grants up to two per
// cycle, round-robin, onto the register file write ports and wakeup bus.
module pregfile_wb_arbiter
    import pregfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int PREG_W  = DEF_PREG_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*PREG_W-1:0] src_prd,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      wren0,
    output logic                      wren1,
    output logic [PREG_W-1:0]         waddr0,
    output logic [PREG_W-1:0]         waddr1,
    output logic [DATA_W-1:0]         wdata0,
    output logic [DATA_W-1:0]         wdata1,
    output logic [1:0]                wakeup_vld,
    output logic [2*PREG_W-1:0]       wakeup_preg,
    output logic [NUM_SRC-1:0]        busy_slots
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] slot_occ;
    logic [NUM_SRC-1:0] slot_drop;
    logic [NUM_SRC-1:0] slot_retire;
    logic [NUM_SRC-1:0] gnt_mask;
    logic [PREG_W-1:0]  slot_prd  [NUM_SRC];
    logic [DATA_W-1:0]  slot_data [NUM_SRC];

    logic             gnt0_vld, gnt1_vld;
    logic [IDX_W-1:0] gnt0_idx, gnt1_idx;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] rr_q, rr_d;

    logic              wren0_q, wren0_d, wren1_q, wren1_d;
    logic [PREG_W-1:0] waddr0_q, waddr0_d, waddr1_q, waddr1_d;
    logic [DATA_W-1:0] wdata0_q, wdata0_d, wdata1_q, wdata1_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
        wb_result_slot #(
            .PREG_W (PREG_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clock      (clock),
            .reset      (reset),
            .load_valid (src_valid[i]),
            .load_prd   (src_prd[i*PREG_W +: PREG_W]),
            .load_data  (src_data[i*DATA_W +: DATA_W]),
            .retire     (slot_retire[i]),
            .ready      (src_ready[i]),
            .occupied   (slot_occ[i]),
            .prd        (slot_prd[i]),
            .data       (slot_data[i])
        );
    end

    // Results aimed at x0 are retired immediately without touching a port.
    always_comb begin
        slot_drop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            slot_drop[i] = slot_occ[i] && (slot_prd[i] == '0);
        end
    end

    always_comb begin
        gnt0_vld = 1'b0;
        gnt1_vld = 1'b0;
        gnt0_idx = '0;
        gnt1_idx = '0;
        scan_idx = '0;
        gnt_mask = '0;
        rr_d     = rr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = IDX_W'((int'(rr_q) + k) % NUM_SRC);
            if (slot_occ[scan_idx] && !slot_drop[scan_idx]) begin
                if (!gnt0_vld) begin
                    gnt0_vld = 1'b1;
                    gnt0_idx = scan_idx;
                end else if (!gnt1_vld) begin
                    gnt1_vld = 1'b1;
                    gnt1_idx = scan_idx;
                end
            end
        end
        if (gnt0_vld) gnt_mask[gnt0_idx] = 1'b1;
        if (gnt1_vld) gnt_mask[gnt1_idx] = 1'b1;
        if (gnt1_vld) begin
            rr_d = IDX_W'(rr_wrap_inc(int'(gnt1_idx), NUM_SRC));
        end else if (gnt0_vld) begin
            rr_d = IDX_W'(rr_wrap_inc(int'(gnt0_idx), NUM_SRC));
        end
        slot_retire = gnt_mask | slot_drop;
    end

    // Ungranted ports keep their last address/data; only the enable drops.
    always_comb begin
        wren0_d  = gnt0_vld;
        wren1_d  = gnt1_vld;
        waddr0_d = waddr0_q;
        waddr1_d = waddr1_q;
        wdata0_d = wdata0_q;
        wdata1_d = wdata1_q;
        if (gnt0_vld) begin
            waddr0_d = slot_prd[gnt0_idx];
            wdata0_d = slot_data[gnt0_idx];
        end
        if (gnt1_vld) begin
            waddr1_d = slot_prd[gnt1_idx];
            wdata1_d = slot_data[gnt1_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q     <= '0;
            wren0_q  <= 1'b0;
            wren1_q  <= 1'b0;
            waddr0_q <= '0;
            waddr1_q <= '0;
            wdata0_q <= '0;
            wdata1_q <= '0;
        end else begin
            rr_q     <= rr_d;
            wren0_q  <= wren0_d;
            wren1_q  <= wren1_d;
            waddr0_q <= waddr0_d;
            waddr1_q <= waddr1_d;
            wdata0_q <= wdata0_d;
            wdata1_q <= wdata1_d;
        end
    end

    assign wren0       = wren0_q;
    assign wren1       = wren1_q;
    assign waddr0      = waddr0_q;
    assign waddr1      = waddr1_q;
    assign wdata0      = wdata0_q;
    assign wdata1      = wdata1_q;
    assign wakeup_vld  = {wren1_q, wren0_q};
    assign wakeup_preg = {waddr1_q, waddr0_q};
    assign busy_slots  = slot_occ;

endmodule

// File: tb/tb_pregfile_wb_arbiter.sv
// Bench for pregfile_wb_arbiter: directed scenarios plus a randomized run
// checked against a queue-based model of slots, drops and round-robin grants.
module tb_pregfile_wb_arbiter;

    localparam int N  = 4;
    localparam int PW = 6;
    localparam int DW = 64;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [N*PW-1:0] src_prd = '0;
    logic [N*DW-1:0] src_data = '0;
    logic            wren0, wren1;
    logic [PW-1:0]   waddr0, waddr1;
    logic [DW-1:0]   wdata0, wdata1;
    logic [1:0]      wakeup_vld;
    logic [2*PW-1:0] wakeup_preg;
    logic [N-1:0]    busy_slots;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pregfile_wb_arbiter #(.NUM_SRC(N), .PREG_W(PW), .DATA_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_prd     (src_prd),
        .src_data    (src_data),
        .wren0       (wren0),
        .wren1       (wren1),
        .waddr0      (waddr0),
        .waddr1      (waddr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .wakeup_vld  (wakeup_vld),
        .wakeup_preg (wakeup_preg),
        .busy_slots  (busy_slots)
    );

    // Reference model state: what each slot holds and what the ports show.
    bit            m_occ   [N];
    logic [PW-1:0] m_prd   [N];
    logic [DW-1:0] m_data  [N];
    int            m_rr = 0;
    bit            m_wren  [2];
    logic [PW-1:0] m_waddr [2];
    logic [DW-1:0] m_wdata [2];
    int            m_gnt[$];
    logic [N-1:0]  m_ready;
    logic [N-1:0]  obs_ready;

    function automatic bit is_granted(input int s);
        foreach (m_gnt[k]) if (m_gnt[k] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_eval(input logic r);
        m_gnt.delete();
        for (int k = 0; k < N; k++) begin
            int s = (m_rr + k) % N;
            if (m_occ[s] && m_prd[s] != 0 && m_gnt.size() < 2) m_gnt.push_back(s);
        end
        for (int s = 0; s < N; s++) begin
            m_ready[2'(s)] = !r && (!m_occ[s] || m_prd[s] == 0 || is_granted(s));
        end
    endfunction

    function automatic void model_commit(input logic [N-1:0] v, input logic [N*PW-1:0] p,
                                         input logic [N*DW-1:0] d, input logic r);
        if (r) begin
            for (int s = 0; s < N; s++) m_occ[s] = 1'b0;
            m_rr = 0;
            for (int k = 0; k < 2; k++) begin
                m_wren[k]  = 1'b0;
                m_waddr[k] = '0;
                m_wdata[k] = '0;
            end
            return;
        end
        for (int k = 0; k < 2; k++) begin
            m_wren[k] = (k < m_gnt.size());
            if (m_wren[k]) begin
                m_waddr[k] = m_prd[m_gnt[k]];
                m_wdata[k] = m_data[m_gnt[k]];
            end
        end
        if (m_gnt.size() > 0) m_rr = (m_gnt[m_gnt.size()-1] + 1) % N;
        for (int s = 0; s < N; s++) begin
            if (v[2'(s)] && m_ready[2'(s)]) begin
                m_occ[s]  = 1'b1;
                m_prd[s]  = p[s*PW +: PW];
                m_data[s] = d[s*DW +: DW];
            end else if (m_occ[s] && (m_prd[s] == 0 || is_granted(s))) begin
                m_occ[s] = 1'b0;
            end
        end
    endfunction

    function automatic logic [N*PW-1:0] prd4(input int a0, input int a1, input int a2, input int a3);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    function automatic logic [N*DW-1:0] dat4(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                             input logic [DW-1:0] a2, input logic [DW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Drives one cycle of inputs on the falling edge, returns just after the rising edge.
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N*PW-1:0] p,
                               input logic [N*DW-1:0] d, input logic r);
        @(negedge clock);
        src_valid = v;
        src_prd   = p;
        src_data  = d;
        reset     = r;
        model_eval(r);
        #1;
        obs_ready = src_ready;
        @(posedge clock);
        model_commit(v, p, d, r);
        #1;
    endtask

    task automatic do_reset();
        drive_cycle('0, '0, '0, 1'b1);
        drive_cycle('0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        drive_cycle('0, '0, '0, 1'b1);
        drive_cycle('0, '0, '0, 1'b1);
        n_cmp++; if (obs_ready !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_ready got=%b exp=0000", obs_ready); end
        n_cmp++; if (wren0 !== 1'b0 || wren1 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wren got=%b%b exp=00", wren1, wren0); end
        n_cmp++; if (waddr0 !== '0 || waddr1 !== '0) begin n_bad++; $display("[TB] FAIL reset_waddr got=%0d/%0d exp=0/0", waddr0, waddr1); end
        n_cmp++; if (wdata0 !== '0 || wdata1 !== '0) begin n_bad++; $display("[TB] FAIL reset_wdata got=%h/%h exp=0/0", wdata0, wdata1); end
        n_cmp++; if (wakeup_vld !== 2'b00 || wakeup_preg !== '0) begin n_bad++; $display("[TB] FAIL reset_wakeup got=%b/%h exp=00/0", wakeup_vld, wakeup_preg); end
        n_cmp++; if (busy_slots !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_busy got=%b exp=0000", busy_slots); end
        drive_cycle('0, '0, '0, 1'b0);
        n_cmp++; if (src_ready !== 4'b1111) begin n_bad++; $display("[TB] FAIL reset_release_ready got=%b exp=1111", src_ready); end
    endtask

    task automatic test_single();
        do_reset();
        drive_cycle(4'b0001, prd4(5, 0, 0, 0), dat4(64'hDEAD, 0, 0, 0), 1'b0);
        n_cmp++; if (wren0 !== 1'b0 || busy_slots !== 4'b0001) begin n_bad++; $display("[TB] FAIL single_e1 wren0=%b busy=%b exp 0/0001", wren0, busy_slots); end
        drive_cycle('0, '0, '0, 1'b0);
        n_cmp++; if (wren0 !== 1'b1 || waddr0 !== 6'd5 || wdata0 !== 64'hDEAD) begin n_bad++; $display("[TB] FAIL single_e2 got wren0=%b waddr0=%0d wdata0=%h exp 1/5/dead", wren0, waddr0, wdata0); end
        n_cmp++; if (wakeup_vld !== 2'b01 || wakeup_preg[PW-1:0] !== 6'd5 || wren1 !== 1'b0) begin n_bad++; $display("[TB] FAIL single_wakeup got vld=%b preg=%h wren1=%b exp 01/5/0", wakeup_vld, wakeup_preg, wren1); end
        drive_cycle('0, '0, '0, 1'b0);
        n_cmp++; if (wren0 !== 1'b0 || waddr0 !== 6'd5 || wakeup_vld !== 2'b00) begin n_bad++; $display("[TB] FAIL single_e3 got wren0=%b waddr0=%0d vld=%b exp 0/5/00", wren0, waddr0, wakeup_vld); end
    endtask

    task automatic test_all_sources();
        do_reset();
        drive_cycle(4'b1111, prd4(1, 2, 3, 4), dat4(100, 101, 102, 103), 1'b0);
        n_cmp++; if (src_ready !== 4'b0011 || busy_slots !== 4'b1111) begin n_bad++; $display("[TB] FAIL all_e1 ready=%b busy=%b exp 0011/1111", src_ready, busy_slots); end
        drive_cycle('0, '0, '0, 1'b0);
        n_cmp++; if (!(wren0 === 1'b1 && wren1 === 1'b1 && waddr0 === 6'd1 && waddr1 === 6'd2 && wdata1 === 64'd101)) begin n_bad++; $display("[TB] FAIL all_e2 got %b%b %0d/%0d %0d exp 11 1/2 101", wren1, wren0, waddr0, waddr1, wdata1); end
        drive_cycle('0, '0, '0, 1'b0);
        n_cmp++; if (!(wren0 === 1'b1 && wren1 === 1'b1 && waddr0 === 6'd3 && waddr1 === 6'd4 && wdata0 === 64'd102)) begin n_bad++; $display("[TB] FAIL all_e3 got %b%b %0d/%0d %0d exp 11 3/4 102", wren1, wren0, waddr0, waddr1, wdata0); end
        drive_cycle(4'b0011, prd4(7, 8, 0, 0), dat4(1, 2, 0, 0), 1'b0);
        drive_cycle('0, '0, '0, 1'b0);
        n_cmp++; if (waddr0 !== 6'd7 || waddr1 !== 6'd8) begin n_bad++; $display("[TB] FAIL all_rr_wrap got %0d/%0d exp 7/8", waddr0, waddr1); end
    endtask

    task automatic test_drop();
        do_reset();
        drive_cycle(4'b0010, prd4(0, 0, 0, 0), dat4(0, 64'h55, 0, 0), 1'b0);
        n_cmp++; if (busy_slots !== 4'b0010 || src_ready[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL drop_e1 busy=%b ready1=%b exp 0010/1", busy_slots, src_ready[1]); end
        for (int c = 0; c < 2; c++) begin
            drive_cycle('0, '0, '0, 1'b0);
            n_cmp++; if (wren0 !== 1'b0 || wren1 !== 1'b0 || wakeup_vld !== 2'b00) begin n_bad++; $display("[TB] FAIL drop_nowrite got %b%b vld=%b exp 00/00", wren1, wren0, wakeup_vld); end
        end
        n_cmp++; if (busy_slots !== 4'b0000) begin n_bad++; $display("[TB] FAIL drop_empty busy=%b exp 0000", busy_slots); end
        drive_cycle(4'b0110, prd4(0, 9, 10, 0), dat4(0, 9, 10, 0), 1'b0);
        drive_cycle('0, '0, '0, 1'b0);
        n_cmp++; if (waddr0 !== 6'd9 || waddr1 !== 6'd10) begin n_bad++; $display("[TB] FAIL drop_rr got %0d/%0d exp 9/10", waddr0, waddr1); end
    endtask

    task automatic test_saturated();
        logic [N*PW-1:0] p;
        logic [N*DW-1:0] d;
        logic [N-1:0]    cur, prev;
        prev = '0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            for (int s = 0; s < N; s++) begin
                p[s*PW +: PW] = 6'(s * 16 + $urandom_range(1, 15));
                d[s*DW +: DW] = {$urandom, $urandom};
            end
            drive_cycle(4'b1111, p, d, 1'b0);
            if (c >= 1) begin
                n_cmp++; if (wren0 !== 1'b1 || wren1 !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_both c=%0d got %b%b exp 11", c, wren1, wren0); end
                n_cmp++; if (waddr0 !== m_waddr[0] || waddr1 !== m_waddr[1] || wdata0 !== m_wdata[0]) begin n_bad++; $display("[TB] FAIL sat_model c=%0d got %0d/%0d exp %0d/%0d", c, waddr0, waddr1, m_waddr[0], m_waddr[1]); end
                cur = '0;
                cur[waddr0[5:4]] = 1'b1;
                cur[waddr1[5:4]] = 1'b1;
                if (c >= 2) begin
                    n_cmp++; if ((cur | prev) !== 4'b1111) begin n_bad++; $display("[TB] FAIL sat_fair c=%0d got %b exp 1111", c, cur | prev); end
                end
                prev = cur;
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        drive_cycle(4'b0101, prd4(11, 0, 12, 0), dat4(11, 0, 12, 0), 1'b0);
        drive_cycle('0, '0, '0, 1'b1);
        n_cmp++; if (obs_ready !== 4'b0000) begin n_bad++; $display("[TB] FAIL midrst_ready got=%b exp=0000", obs_ready); end
        n_cmp++; if (wren0 !== 1'b0 || wren1 !== 1'b0 || wakeup_vld !== 2'b00 || waddr0 !== '0) begin n_bad++; $display("[TB] FAIL midrst_out got %b%b vld=%b a0=%0d exp 00/00/0", wren1, wren0, wakeup_vld, waddr0); end
        n_cmp++; if (busy_slots !== 4'b0000) begin n_bad++; $display("[TB] FAIL midrst_busy got=%b exp=0000", busy_slots); end
        drive_cycle('0, '0, '0, 1'b0);
        n_cmp++; if (obs_ready !== 4'b1111 || wren0 !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_after ready=%b wren0=%b exp 1111/0", obs_ready, wren0); end
        drive_cycle(4'b1100, prd4(0, 0, 13, 14), dat4(0, 0, 13, 14), 1'b0);
        n_cmp++; if (wren0 !== 1'b0 || wakeup_vld !== 2'b00) begin n_bad++; $display("[TB] FAIL midrst_nowrite wren0=%b vld=%b exp 0/00", wren0, wakeup_vld); end
        drive_cycle('0, '0, '0, 1'b0);
        n_cmp++; if (waddr0 !== 6'd13 || waddr1 !== 6'd14) begin n_bad++; $display("[TB] FAIL midrst_rr got %0d/%0d exp 13/14", waddr0, waddr1); end
    endtask

    task automatic test_back_to_back();
        logic       exp_wren [6];
        logic [5:0] exp_addr [6];
        exp_wren = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_addr = '{6'd0, 6'd20, 6'd21, 6'd22, 6'd22, 6'd22};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive_cycle(4'b1000, prd4(0, 0, 0, 20 + c), dat4(0, 0, 0, 64'(c)), 1'b0);
            else       drive_cycle('0, '0, '0, 1'b0);
            n_cmp++; if (wren0 !== exp_wren[c] || wren1 !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_wren c=%0d got %b%b exp 0%b", c, wren1, wren0, exp_wren[c]); end
            if (c >= 1) begin
                n_cmp++; if (waddr0 !== exp_addr[c]) begin n_bad++; $display("[TB] FAIL b2b_addr c=%0d got %0d exp %0d", c, waddr0, exp_addr[c]); end
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0]    v;
        logic [N*PW-1:0] p;
        logic [N*DW-1:0] d;
        logic            r;
        logic [N-1:0]    m_busy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = 4'($urandom);
            for (int s = 0; s < N; s++) begin
                p[s*PW +: PW] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
                d[s*DW +: DW] = {$urandom, $urandom};
            end
            r = ($urandom_range(0, 39) == 0);
            drive_cycle(v, p, d, r);
            for (int s = 0; s < N; s++) m_busy[2'(s)] = m_occ[s];
            n_cmp++; if (obs_ready !== m_ready) begin n_bad++; $display("[TB] FAIL rnd_ready c=%0d got %b exp %b", c, obs_ready, m_ready); end
            n_cmp++; if (wren0 !== m_wren[0] || wren1 !== m_wren[1]) begin n_bad++; $display("[TB] FAIL rnd_wren c=%0d got %b%b exp %b%b", c, wren1, wren0, m_wren[1], m_wren[0]); end
            n_cmp++; if (waddr0 !== m_waddr[0] || waddr1 !== m_waddr[1]) begin n_bad++; $display("[TB] FAIL rnd_waddr c=%0d got %0d/%0d exp %0d/%0d", c, waddr0, waddr1, m_waddr[0], m_waddr[1]); end
            n_cmp++; if (wdata0 !== m_wdata[0] || wdata1 !== m_wdata[1]) begin n_bad++; $display("[TB] FAIL rnd_wdata c=%0d got %h/%h exp %h/%h", c, wdata0, wdata1, m_wdata[0], m_wdata[1]); end
            n_cmp++; if (wakeup_vld !== {m_wren[1], m_wren[0]} || wakeup_preg !== {m_waddr[1], m_waddr[0]}) begin n_bad++; $display("[TB] FAIL rnd_wakeup c=%0d got %b/%h", c, wakeup_vld, wakeup_preg); end
            n_cmp++; if (busy_slots !== m_busy) begin n_bad++; $display("[TB] FAIL rnd_busy c=%0d got %b exp %b", c, busy_slots, m_busy); end
        end
    endtask

    initial begin
        for (int s = 0; s < N; s++) begin
            m_occ[s]  = 1'b0;
            m_prd[s]  = '0;
            m_data[s] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            m_wren[k]  = 1'b0;
            m_waddr[k] = '0;
            m_wdata[k] = '0;
        end
        test_reset();
        test_single();
        test_all_sources();
        test_drop();
        test_saturated();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pregfile_wb_arbiter.md
Name: pregfile_wb_arbiter

Overview:
Writeback-side driver for the 64x64 4R2W physical register file. Collects results from NUM_SRC execution-unit result channels (ALU0, ALU1, MDU, LSU) over valid/ready handshakes and holds each result in a per-source slot. Grants up to two held results per cycle, round-robin, onto the register file's two write ports. Mirrors each write onto wakeup outputs for the busy table and issue queues.

Parameters:
NUM_SRC, 4, number of result sources (index 0=ALU0, 1=ALU1, 2=MDU, 3=LSU)
PREG_W, 6, physical register index width (matches `PREG_LENGTH)
DATA_W, 64, result data width

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
src_valid  in  NUM_SRC  per-source result valid
src_ready  out  NUM_SRC  per-source slot can accept
src_prd  in  NUM_SRC*PREG_W  per-source destination preg, packed, source i at [i*PREG_W +: PREG_W]
src_data  in  NUM_SRC*DATA_W  per-source result data, packed likewise
wren0 / wren1  out  1  register file write enables
waddr0 / waddr1  out  PREG_W  register file write addresses
wdata0 / wdata1  out  DATA_W  register file write data
wakeup_vld  out  2  wakeup valid, bit k mirrors wren_k
wakeup_preg  out  2*PREG_W  wakeup preg, slice k mirrors waddr_k
busy_slots  out  NUM_SRC  debug/perf: slot occupied

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (reset high at posedge): all slots empty; rr pointer=0; wren0/1=0; waddr0/1=0; wdata0/1=0; wakeup_vld=0; wakeup_preg=0. src_ready forced 0 while reset is high.
- Slot i: one entry {prd, data}. src_ready[i] = !reset && (slot empty || slot granted/dropped this cycle). The slot loads on posedge when src_valid[i] && src_ready[i]. Full throughput is one result per source per cycle while that source keeps winning grants.
- Drop rule: a held entry with prd==0 is retired in the cycle it is held. It consumes no port and produces no wakeup, since x0 is never written.
- Arbitration (combinational, each cycle): scan occupied, non-drop slots in order rr, rr+1, ... mod NUM_SRC. The first found goes to port 0, the second to port 1. Ungranted slots hold their contents; no starvation.
- rr update: if any grant, rr <= (index of last granted slot + 1) mod NUM_SRC; else rr unchanged. Drops do not move rr.
- Write outputs are registered. The grant in cycle C drives wren/waddr/wdata in cycle C+1. With no grant on a port, its wren is 0 and its waddr/wdata hold their last values. wakeup_* are identical registered copies.
- Latency: handshake at edge E -> slot visible cycle E+1 -> earliest wren cycle E+2. The register file's bypass makes data readable in E+2 and stored at the end of E+2.
- Two ports never carry the same slot. Duplicate prd across slots is a rename bug; no check is done. Port 1 wins in the register file.
- Reset mid-operation: held and in-flight results are discarded with no write. Outputs are 0 in the cycle after the reset edge.
- A single grant always uses port 0; port 1 is used only when two slots are granted.

Decomposition:
- Shared defines header: PREG_W/DATA_W via the existing `PREG_LENGTH / `PREG_RANGE; source index constants SRC_ALU0..SRC_LSU.
- Sub-module wb_result_slot: one-entry holding buffer with load/retire, empty flag and ready generation; instantiated NUM_SRC times.
- Arbiter and output registers stay in the top module.

Test Plan:
- Single ALU0 result prd=5, data=0xDEAD at edge E: wren0=1, waddr0=5, wdata0=0xDEAD, wakeup_vld=2'b01 in cycle E+2 only; wren1=0 throughout.
- All 4 sources valid at edge E (prd 1,2,3,4), rr=0: cycle E+2 ports get 1/2; E+3 ports get 3/4; src_ready[2,3]=0 during E+1; rr ends at 0.
- ALU1 result with prd=0: no wren/wakeup ever; src_ready[1]=1 the following cycle; rr unchanged.
- ALU0 valid every cycle with ALU1/MDU/LSU also saturated: each source gets exactly one grant per 2-cycle window; no source waits more than 2 arbitration cycles.
- Sources 0 and 2 held, reset asserted for one cycle before the grant registers: no wren/wakeup after reset; slots empty; rr=0; src_ready=0 during reset and 1 after.
- Back-to-back LSU results for 3 cycles, other sources idle: wren0 high 3 consecutive cycles with waddr0 following prd order; wren1 stays 0.
